ldpc_minsum_decoder: RTL
========================

Name: ldpc_minsum_decoder

Overview:
- Parametrised, iterative min-sum LDPC decoder. Successor to the fixed-size Decoder/VarToCheck/CheckToVar/Belief set.
- N, M, LLR width, the parity-check matrix and the iteration limit are all parameters.
- Adds a start/busy/done handshake, early termination on zero syndrome, saturating arithmetic and iteration reporting.
- Takes a channel LLR frame from the demodulator and returns hard decisions plus final beliefs.

Parameters:
- N, 10, number of variable nodes (codeword bits).
- M, 5, number of check nodes.
- W, 8, signed LLR and message width (two's complement).
- MAX_ITER, 8, iteration limit (>=1).
- H_MATRIX, M*N bits, parity-check matrix; bit m*N+n set means check m touches variable n.
  - Default rows: r0={0,1,2,3}, r1={0,4,5,6}, r2={1,4,7,8}, r3={2,5,7,9}, r4={3,6,8,9}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request decode of llr_in; sampled only in IDLE.
- llr_in  in  N*W  channel LLRs; var n at [n*W+:W]; positive means bit 0.
- busy  out  1  high in CHECK, VAR and DONE.
- done  out  1  one-cycle pulse, high while in DONE.
- converged  out  1  syndrome was zero at termination; valid from done onward.
- iter_count  out  clog2(MAX_ITER+1)  iterations executed.
- corrected_seq  out  N  hard decisions; bit n = 1 iff belief n < 0.
- belief_out  out  N*W  final saturated beliefs.

Behaviour:
- Saturation range is ±(2^(W-1)-1).
  - llr_in = -2^(W-1) is clamped to -(2^(W-1)-1) at load.
  - All sums use widened intermediates, then clamp to the range.
- Zero is treated as non-negative for signs and hard decisions.
- States: IDLE, CHECK, VAR, DONE.
- IDLE, start=1: latch clamped llr_in into ch[n]; set V2C[n][m]=ch[n] for every H edge; clear iter_count, converged, corrected_seq, belief_out; go to CHECK.
- CHECK (one cycle): for every edge, register C2V[m][n].
  - Magnitude = min |V2C[n'][m]| over other neighbours n'≠n of check m.
  - Sign = product of their signs.
  - A degree-1 check gives C2V = 0.
  - Next state: VAR.
- VAR (one cycle):
  - V2C[n][m] = sat(ch[n] + Σ C2V[m'][n], m'≠m).
  - belief[n] = sat(ch[n] + Σ all C2V[m][n]).
  - Register corrected_seq and belief_out; iter_count += 1.
  - Syndrome is computed combinationally from the new hard bits.
  - Zero syndrome: go to DONE with converged=1.
  - Else if new iter_count == MAX_ITER: go to DONE with converged=0.
  - Else: go to CHECK.
- DONE (one cycle): done=1, then go to IDLE.
  - converged, iter_count, corrected_seq and belief_out hold until the next accepted start.
- Latency: a start accepted at edge E0 asserts done in the cycle after edge E0+2k (k = iterations run).
  - done high after 2 cycles minimum, 2*MAX_ITER cycles maximum.
- At least one iteration always runs; the channel syndrome is not checked at load.
- start while busy (CHECK, VAR or DONE) is ignored. start in the cycle after DONE (IDLE again) is accepted.
- llr_in is only sampled at the accepting edge; later changes have no effect.
- rst at any edge, including mid-decode:
  - state becomes IDLE.
  - busy, done, converged, iter_count, corrected_seq, belief_out and all message registers become 0.
  - A start asserted together with rst is ignored.

Test Plan:
- All llr_in=+13, start pulse:
  - done 2 cycles after start, converged=1, iter_count=1.
  - corrected_seq=0; every belief=39.
- llr_in=+13 except var0=-5 (single error):
  - converged=1, iter_count=1, corrected_seq=0.
  - belief var0=21, belief var1=21.
- Codeword bits {0,1,4}: llr -13 on those, +13 elsewhere:
  - converged=1, iter_count=1, corrected_seq=10'b0000010011.
  - belief var0=-39.
- All llr=0 except var0=-1:
  - all C2V stay 0; runs to MAX_ITER=8, done 16 cycles after start.
  - converged=0, iter_count=8, corrected_seq=10'b0000000001.
- Saturation, all llr=+127:
  - every belief=127 (clamped), corrected_seq=0.
  - Repeat with var0=-128: loaded as -127.
  - Check no wrap at any step.
- Control:
  - start pulses during CHECK/VAR are ignored; done appears exactly once.
  - rst asserted in a VAR cycle: next cycle busy=0, done=0, outputs 0.
  - A fresh start then decodes correctly.

Source files
------------

// File: rtl/ldpc_minsum_decoder_if.sv
// Start/result interface of the min-sum LDPC decoder: the requester drives start and
// the channel LLR frame, and the decoder returns status, hard decisions and final beliefs.
interface ldpc_minsum_decoder_if #(
  parameter int N        = 10,
  parameter int W        = 8,
  parameter int MAX_ITER = 8
);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic           start;
  logic [N*W-1:0] llr_in;
  logic           busy;
  logic           done;
  logic           converged;
  logic [IW-1:0]  iter_count;
  logic [N-1:0]   corrected_seq;
  logic [N*W-1:0] belief_out;

  modport master (
    output start, llr_in,
    input  busy, done, converged, iter_count, corrected_seq, belief_out
  );

  modport slave (
    input  start, llr_in,
    output busy, done, converged, iter_count, corrected_seq, belief_out
  );
endinterface

// File: rtl/ldpc_minsum_decoder.sv
// Iterative min-sum LDPC decoder with saturating messages and early stop on zero syndrome.
// One iteration takes two cycles: a check-node update (CHECK) and a variable-node update (VAR).
module ldpc_minsum_decoder #(
  parameter int N        = 10,
  parameter int M        = 5,
  parameter int W        = 8,
  parameter int MAX_ITER = 8,
  parameter logic [M*N-1:0] H_MATRIX = {10'b1101001000, 10'b1010100100, 10'b0110010010,
                                        10'b0001110001, 10'b0000001111}
) (
  input logic                  clk,
  input logic                  rst,
  ldpc_minsum_decoder_if.slave bus
);
  localparam int IW = $clog2(MAX_ITER + 1);
  // Sum of the channel value plus M messages can reach (M+1)*(2^(W-1)-1).
  localparam int SW = W + $clog2(M + 1) + 1;

  typedef logic signed [W-1:0]  msg_t;
  typedef logic signed [SW-1:0] wide_t;
  typedef enum logic [1:0] {IDLE, CHECK, VAR, DONE} state_t;

  localparam msg_t  MSG_MAX  = msg_t'((2 ** (W - 1)) - 1);
  localparam msg_t  MSG_MOST_NEG = msg_t'(2 ** (W - 1));
  localparam wide_t WIDE_MAX = wide_t'(MSG_MAX);

  function automatic msg_t sat(input wide_t x);
    if (x > WIDE_MAX)  return MSG_MAX;
    if (x < -WIDE_MAX) return -MSG_MAX;
    return msg_t'(x);
  endfunction

  // Messages never hold the most negative code, so negation cannot overflow here.
  function automatic logic [W-1:0] mag(input msg_t x);
    msg_t a;
    a = x[W-1] ? -x : x;
    return a;
  endfunction

  function automatic msg_t clamp_llr(input msg_t x);
    return (x == MSG_MOST_NEG) ? -MSG_MAX : x;
  endfunction

  state_t        state;
  msg_t          ch       [N];
  msg_t          v2c      [M][N];
  msg_t          c2v      [M][N];
  msg_t          belief_q [N];
  logic          busy_q;
  logic          done_q;
  logic          converged_q;
  logic [IW-1:0] iter_q;
  logic [N-1:0]  seq_q;

  msg_t           c2v_next    [M][N];
  msg_t           v2c_next    [M][N];
  msg_t           belief_next [N];
  logic [N-1:0]   hard_next;
  logic [M-1:0]   syndrome;
  logic [IW-1:0]  iter_next;
  logic [N*W-1:0] belief_flat;
  logic [W-1:0]   min_mag;
  logic [W-1:0]   cur_mag;
  logic           neg;
  logic           found;
  wide_t          total;

  // Check-node update: each edge gets the min magnitude and sign product of the other edges.
  always_comb begin
    // NOTE: scratch variables get a default before any conditional use so no latch is inferred.
    min_mag = '0;
    cur_mag = '0;
    neg     = 1'b0;
    found   = 1'b0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        // NOTE: blocking assignments here model an ordered fold inside one combinational pass;
        // state registers use non-blocking assignments only.
        min_mag = '1;
        neg     = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
          cur_mag = mag(v2c[m][k]);
          if (k != n && H_MATRIX[m*N+k]) begin
            found = 1'b1;
            neg   = neg ^ v2c[m][k][W-1];
            if (cur_mag < min_mag) min_mag = cur_mag;
          end
        end
        if (!H_MATRIX[m*N+n] || !found) c2v_next[m][n] = '0;
        else if (neg)                    c2v_next[m][n] = -msg_t'(min_mag);
        else                             c2v_next[m][n] = msg_t'(min_mag);
      end
    end
  end

  // Variable-node update: the total belief, minus each edge's own contribution, is its new V2C.
  always_comb begin
    total     = '0;
    hard_next = '0;
    for (int n = 0; n < N; n++) begin
      total = wide_t'(ch[n]);
      for (int m = 0; m < M; m++) begin
        if (H_MATRIX[m*N+n]) total = total + wide_t'(c2v[m][n]);
      end
      belief_next[n] = sat(total);
      hard_next[n]   = belief_next[n][W-1];
      for (int m = 0; m < M; m++) begin
        v2c_next[m][n] = H_MATRIX[m*N+n] ? sat(total - wide_t'(c2v[m][n])) : '0;
      end
    end
    for (int m = 0; m < M; m++) begin
      syndrome[m] = ^(hard_next & H_MATRIX[m*N +: N]);
    end
    iter_next = iter_q + 1'b1;
  end

  always_comb begin
    belief_flat = '0;
    for (int n = 0; n < N; n++) belief_flat[n*W +: W] = belief_q[n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      iter_q      <= '0;
      seq_q       <= '0;
      // NOTE: the message arrays are reset too, so a mid-decode reset leaves no stale state.
      for (int n = 0; n < N; n++) begin
        ch[n]       <= '0;
        belief_q[n] <= '0;
        for (int m = 0; m < M; m++) begin
          v2c[m][n] <= '0;
          c2v[m][n] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            for (int n = 0; n < N; n++) begin
              ch[n]       <= clamp_llr(bus.llr_in[n*W +: W]);
              belief_q[n] <= '0;
              for (int m = 0; m < M; m++) begin
                v2c[m][n] <= H_MATRIX[m*N+n] ? clamp_llr(bus.llr_in[n*W +: W]) : '0;
              end
            end
            converged_q <= 1'b0;
            iter_q      <= '0;
            seq_q       <= '0;
            busy_q      <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: begin
          for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) c2v[m][n] <= c2v_next[m][n];
          end
          state <= VAR;
        end
        VAR: begin
          for (int n = 0; n < N; n++) begin
            belief_q[n] <= belief_next[n];
            for (int m = 0; m < M; m++) v2c[m][n] <= v2c_next[m][n];
          end
          seq_q  <= hard_next;
          iter_q <= iter_next;
          if (syndrome == '0) begin
            converged_q <= 1'b1;
            done_q      <= 1'b1;
            state       <= DONE;
          end else if (iter_next == IW'(MAX_ITER)) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= CHECK;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.converged     = converged_q;
  assign bus.iter_count    = iter_q;
  assign bus.corrected_seq = seq_q;
  assign bus.belief_out    = belief_flat;
endmodule
